dual_issue_scheduler: RTL and testbench

- In-order issue scheduler between decode and the even/odd execution pipes of the SPU.
- Holds one fetched instruction pair and tracks pending register writes in a per-register latency scoreboard.
- Each cycle it issues zero, one or both instructions to the correct pipes, serialising same-pipe pairs and intra-pair dependencies. It drops the held pair on a branch flush.
- It replaces ad-hoc stage-by-stage comparison with a countdown scoreboard.

---
 rtl/dual_issue_scheduler.sv | 170 +++++++++++++++++
 tb/tb_dual_issue_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler: holds one decoded pair, steers it to the even/odd pipes,
// and gates issue on a per-register countdown scoreboard of pending write latencies.
module dual_issue_scheduler #(
    parameter int NUM_REGS = 128,
    parameter int LAT_W    = 4,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_pair_valid,
    output logic             o_pair_ready,
    input  logic             i_in1_pipe,
    input  logic             i_in1_wr,
    input  logic [6:0]       i_in1_dst,
    input  logic [LAT_W-1:0] i_in1_lat,
    input  logic [2:0]       i_in1_src_use,
    input  logic [6:0]       i_in1_ra,
    input  logic [6:0]       i_in1_rb,
    input  logic [6:0]       i_in1_rc,
    input  logic             i_in2_pipe,
    input  logic             i_in2_wr,
    input  logic [6:0]       i_in2_dst,
    input  logic [LAT_W-1:0] i_in2_lat,
    input  logic [2:0]       i_in2_src_use,
    input  logic [6:0]       i_in2_ra,
    input  logic [6:0]       i_in2_rb,
    input  logic [6:0]       i_in2_rc,
    input  logic             i_flush,
    output logic             o_even_valid,
    output logic             o_odd_valid,
    output logic             o_even_slot,
    output logic             o_odd_slot,
    output logic [6:0]       o_even_dst,
    output logic [6:0]       o_odd_dst,
    output logic             o_even_wr,
    output logic             o_odd_wr,
    output logic [CNT_W-1:0] o_stall_cycles
);

    typedef struct packed {
        logic             pipe;
        logic             wr;
        logic [6:0]       dst;
        logic [LAT_W-1:0] lat;
        logic [2:0]       src_use;
        logic [6:0]       ra;
        logic [6:0]       rb;
        logic [6:0]       rc;
    } instr_t;

    instr_t             r_s1, r_s2;
    logic               r_p1, r_p2;
    logic [LAT_W-1:0]   r_cnt [NUM_REGS];

    instr_t             w_in1, w_in2;
    logic [NUM_REGS-1:0] w_rdy;
    logic               w_src_ok1, w_src_ok2, w_dst_ok1, w_dst_ok2;
    logic               w_raw12, w_waw12, w_pair_ok;
    logic               w_can1, w_can2, w_capture;
    logic               w_ev1, w_ev2, w_od1, w_od2;
    logic [LAT_W-1:0]   w_load1, w_load2;

    assign w_in1 = '{pipe: i_in1_pipe, wr: i_in1_wr, dst: i_in1_dst, lat: i_in1_lat,
                     src_use: i_in1_src_use, ra: i_in1_ra, rb: i_in1_rb, rc: i_in1_rc};
    assign w_in2 = '{pipe: i_in2_pipe, wr: i_in2_wr, dst: i_in2_dst, lat: i_in2_lat,
                     src_use: i_in2_src_use, ra: i_in2_ra, rb: i_in2_rb, rc: i_in2_rc};

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_rdy[i] = (r_cnt[i] == '0);
        end
    end

    // src_use bit order is {ra, rb, rc}
    assign w_src_ok1 = (!r_s1.src_use[2] || w_rdy[r_s1.ra]) &&
                       (!r_s1.src_use[1] || w_rdy[r_s1.rb]) &&
                       (!r_s1.src_use[0] || w_rdy[r_s1.rc]);
    assign w_src_ok2 = (!r_s2.src_use[2] || w_rdy[r_s2.ra]) &&
                       (!r_s2.src_use[1] || w_rdy[r_s2.rb]) &&
                       (!r_s2.src_use[0] || w_rdy[r_s2.rc]);
    assign w_dst_ok1 = !r_s1.wr || w_rdy[r_s1.dst];
    assign w_dst_ok2 = !r_s2.wr || w_rdy[r_s2.dst];

    assign w_raw12 = r_s1.wr && ((r_s2.src_use[2] && (r_s2.ra == r_s1.dst)) ||
                                 (r_s2.src_use[1] && (r_s2.rb == r_s1.dst)) ||
                                 (r_s2.src_use[0] && (r_s2.rc == r_s1.dst)));
    assign w_waw12   = r_s1.wr && r_s2.wr && (r_s1.dst == r_s2.dst);
    assign w_pair_ok = (r_s1.pipe != r_s2.pipe) && !w_raw12 && !w_waw12;

    assign w_can1 = r_p1 && !i_flush && w_src_ok1 && w_dst_ok1;
    assign w_can2 = r_p2 && !i_flush && w_src_ok2 && w_dst_ok2 &&
                    (!r_p1 || w_can1) && (!w_can1 || w_pair_ok);

    assign o_pair_ready = !i_flush && (!r_p1 || w_can1) && (!r_p2 || w_can2);
    assign w_capture    = i_pair_valid && o_pair_ready;

    assign w_ev1 = w_can1 && !r_s1.pipe;
    assign w_ev2 = w_can2 && !r_s2.pipe;
    assign w_od1 = w_can1 &&  r_s1.pipe;
    assign w_od2 = w_can2 &&  r_s2.pipe;

    // Load lat-1 so a consumer sees cnt==0 exactly lat cycles after issue; lat 0 acts as 1
    assign w_load1 = (r_s1.lat == '0) ? '0 : r_s1.lat - 1'b1;
    assign w_load2 = (r_s2.lat == '0) ? '0 : r_s2.lat - 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_p1 <= 1'b0;
            r_p2 <= 1'b0;
            r_s1 <= '0;
            r_s2 <= '0;
        end else if (i_flush) begin
            r_p1 <= 1'b0;
            r_p2 <= 1'b0;
        end else if (w_capture) begin
            r_p1 <= 1'b1;
            r_p2 <= 1'b1;
            r_s1 <= w_in1;
            r_s2 <= w_in2;
        end else begin
            r_p1 <= r_p1 && !w_can1;
            r_p2 <= r_p2 && !w_can2;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_reset) begin
                r_cnt[i] <= '0;
            end else if (w_can1 && r_s1.wr && (r_s1.dst == 7'(i))) begin
                r_cnt[i] <= w_load1;
            end else if (w_can2 && r_s2.wr && (r_s2.dst == 7'(i))) begin
                r_cnt[i] <= w_load2;
            end else if (r_cnt[i] != '0) begin
                r_cnt[i] <= r_cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_even_valid <= 1'b0;
            o_odd_valid  <= 1'b0;
            o_even_slot  <= 1'b0;
            o_odd_slot   <= 1'b0;
            o_even_dst   <= '0;
            o_odd_dst    <= '0;
            o_even_wr    <= 1'b0;
            o_odd_wr     <= 1'b0;
        end else begin
            o_even_valid <= w_ev1 || w_ev2;
            o_odd_valid  <= w_od1 || w_od2;
            o_even_slot  <= !w_ev1 && w_ev2;
            o_odd_slot   <= !w_od1 && w_od2;
            o_even_dst   <= w_ev1 ? r_s1.dst : r_s2.dst;
            o_odd_dst    <= w_od1 ? r_s1.dst : r_s2.dst;
            o_even_wr    <= w_ev1 ? r_s1.wr : (w_ev2 && r_s2.wr);
            o_odd_wr     <= w_od1 ? r_s1.wr : (w_od2 && r_s2.wr);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_stall_cycles <= '0;
        end else if ((r_p1 || r_p2) && !i_flush && !w_can1 && !w_can2) begin
            o_stall_cycles <= o_stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler: steps through issue, serialisation, RAW, flush
// and reset scenarios with hand-computed expectations checked by immediate assertions.
module tb_dual_issue_scheduler;

    logic       clk;
    logic       reset;
    logic       pair_valid;
    logic       pair_ready;
    logic       in1_pipe, in1_wr, in2_pipe, in2_wr;
    logic [6:0] in1_dst, in1_ra, in1_rb, in1_rc;
    logic [6:0] in2_dst, in2_ra, in2_rb, in2_rc;
    logic [3:0] in1_lat, in2_lat;
    logic [2:0] in1_src_use, in2_src_use;
    logic       flush;
    logic       even_valid, odd_valid, even_slot, odd_slot, even_wr, odd_wr;
    logic [6:0] even_dst, odd_dst;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    dual_issue_scheduler #(.NUM_REGS(128), .LAT_W(4), .CNT_W(16)) dut (
        .i_clk(clk), .i_reset(reset), .i_pair_valid(pair_valid), .o_pair_ready(pair_ready),
        .i_in1_pipe(in1_pipe), .i_in1_wr(in1_wr), .i_in1_dst(in1_dst), .i_in1_lat(in1_lat),
        .i_in1_src_use(in1_src_use), .i_in1_ra(in1_ra), .i_in1_rb(in1_rb), .i_in1_rc(in1_rc),
        .i_in2_pipe(in2_pipe), .i_in2_wr(in2_wr), .i_in2_dst(in2_dst), .i_in2_lat(in2_lat),
        .i_in2_src_use(in2_src_use), .i_in2_ra(in2_ra), .i_in2_rb(in2_rb), .i_in2_rc(in2_rc),
        .i_flush(flush),
        .o_even_valid(even_valid), .o_odd_valid(odd_valid),
        .o_even_slot(even_slot), .o_odd_slot(odd_slot),
        .o_even_dst(even_dst), .o_odd_dst(odd_dst),
        .o_even_wr(even_wr), .o_odd_wr(odd_wr),
        .o_stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set1(input logic pipe, input logic wr, input logic [6:0] dst,
                        input logic [3:0] lat, input logic [2:0] use_m,
                        input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc);
        in1_pipe = pipe; in1_wr = wr; in1_dst = dst; in1_lat = lat;
        in1_src_use = use_m; in1_ra = ra; in1_rb = rb; in1_rc = rc;
    endtask

    task automatic set2(input logic pipe, input logic wr, input logic [6:0] dst,
                        input logic [3:0] lat, input logic [2:0] use_m,
                        input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc);
        in2_pipe = pipe; in2_wr = wr; in2_dst = dst; in2_lat = lat;
        in2_src_use = use_m; in2_ra = ra; in2_rb = rb; in2_rc = rc;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; pair_valid = 1'b0;
        set1(0, 0, 0, 0, 3'b000, 0, 0, 0);
        set2(0, 0, 0, 0, 3'b000, 0, 0, 0);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_even_valid", even_valid, 0);
        chk("rst_odd_valid", odd_valid, 0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_pair_ready", pair_ready, 1);

        // independent pair, opposite pipes
        set1(0, 1, 3, 2, 3'b100, 1, 0, 0);
        set2(1, 1, 4, 4, 3'b100, 2, 0, 0);
        pair_valid = 1'b1;
        tick();
        pair_valid = 1'b0;
        chk("ind_ready", pair_ready, 1);
        chk("ind_pre_even", even_valid, 0);
        tick();
        chk("ind_even_valid", even_valid, 1);
        chk("ind_odd_valid", odd_valid, 1);
        chk("ind_even_slot", even_slot, 0);
        chk("ind_odd_slot", odd_slot, 1);
        chk("ind_even_dst", even_dst, 3);
        chk("ind_odd_dst", odd_dst, 4);

        // both on even pipe: serialised over two cycles
        set1(0, 1, 20, 1, 3'b000, 0, 0, 0);
        set2(0, 1, 21, 1, 3'b000, 0, 0, 0);
        pair_valid = 1'b1;
        tick();
        pair_valid = 1'b0;
        chk("same_ready", pair_ready, 0);
        tick();
        chk("same_c1_even", even_valid, 1);
        chk("same_c1_slot", even_slot, 0);
        chk("same_c1_dst", even_dst, 20);
        chk("same_c1_odd", odd_valid, 0);
        chk("same_c1_ready", pair_ready, 1);
        tick();
        chk("same_c2_even", even_valid, 1);
        chk("same_c2_slot", even_slot, 1);
        chk("same_c2_dst", even_dst, 21);
        chk("same_c2_odd", odd_valid, 0);
        chk("same_stall", stall_cycles, 0);
        tick();
        chk("same_idle_even", even_valid, 0);

        // intra-pair RAW on r5 with latency 6
        set1(0, 1, 5, 6, 3'b000, 0, 0, 0);
        set2(1, 0, 0, 1, 3'b100, 5, 0, 0);
        pair_valid = 1'b1;
        tick();
        pair_valid = 1'b0;
        chk("raw_t_ready", pair_ready, 0);
        tick();
        chk("raw_t1_even", even_valid, 1);
        chk("raw_t1_odd", odd_valid, 0);
        chk("raw_t1_ready", pair_ready, 0);
        repeat (4) tick();
        chk("raw_t5_ready", pair_ready, 0);
        chk("raw_t5_odd", odd_valid, 0);
        chk("raw_t5_stall", stall_cycles, 4);
        tick();
        chk("raw_t6_ready", pair_ready, 1);
        chk("raw_t6_stall", stall_cycles, 5);
        chk("raw_t6_odd", odd_valid, 0);
        tick();
        chk("raw_t7_odd", odd_valid, 1);
        chk("raw_t7_slot", odd_slot, 1);
        chk("raw_t7_wr", odd_wr, 0);
        chk("raw_t7_even", even_valid, 0);

        // cross-pair RAW with latency 1: back-to-back, no bubble
        set1(0, 1, 10, 1, 3'b000, 0, 0, 0);
        set2(1, 1, 11, 1, 3'b000, 0, 0, 0);
        pair_valid = 1'b1;
        tick();
        chk("xp_a_ready", pair_ready, 1);
        set1(0, 1, 12, 1, 3'b100, 10, 0, 0);
        set2(1, 0, 0, 1, 3'b000, 0, 0, 0);
        tick();
        pair_valid = 1'b0;
        chk("xp_a_even", even_valid, 1);
        chk("xp_a_dst", even_dst, 10);
        chk("xp_b_ready", pair_ready, 1);
        tick();
        chk("xp_b_even", even_valid, 1);
        chk("xp_b_dst", even_dst, 12);
        chk("xp_b_odd", odd_valid, 1);
        chk("xp_b_odd_slot", odd_slot, 1);
        chk("xp_stall", stall_cycles, 5);

        // flush while instr2 waits on r5 (cnt 3)
        set1(0, 1, 5, 6, 3'b000, 0, 0, 0);
        set2(1, 0, 0, 1, 3'b100, 5, 0, 0);
        pair_valid = 1'b1;
        tick();
        pair_valid = 1'b0;
        tick(); tick(); tick();
        flush = 1'b1;
        #1;
        chk("fl_ready_low", pair_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_ready_high", pair_ready, 1);
        chk("fl_even", even_valid, 0);
        chk("fl_odd", odd_valid, 0);
        chk("fl_stall", stall_cycles, 7);
        set1(1, 0, 0, 1, 3'b100, 5, 0, 0);
        set2(0, 0, 0, 1, 3'b000, 0, 0, 0);
        pair_valid = 1'b1;
        tick();
        pair_valid = 1'b0;
        chk("fl_wait_ready", pair_ready, 0);
        tick();
        chk("fl_wait_odd", odd_valid, 0);
        chk("fl_go_ready", pair_ready, 1);
        tick();
        chk("fl_go_odd", odd_valid, 1);
        chk("fl_go_odd_slot", odd_slot, 0);
        chk("fl_go_even", even_valid, 1);
        chk("fl_go_even_slot", even_slot, 1);
        chk("fl_go_stall", stall_cycles, 8);

        // reset mid-operation with cnt[r7]=5 and instr2 pending
        set1(0, 1, 7, 6, 3'b000, 0, 0, 0);
        set2(1, 0, 0, 1, 3'b100, 7, 0, 0);
        pair_valid = 1'b1;
        tick();
        pair_valid = 1'b0;
        tick();
        chk("mr_pre_even", even_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mr_even", even_valid, 0);
        chk("mr_odd", odd_valid, 0);
        chk("mr_stall", stall_cycles, 0);
        chk("mr_ready", pair_ready, 1);
        set1(0, 0, 0, 1, 3'b100, 7, 0, 0);
        set2(1, 0, 0, 1, 3'b000, 0, 0, 0);
        pair_valid = 1'b1;
        tick();
        pair_valid = 1'b0;
        chk("mr_new_ready", pair_ready, 1);
        tick();
        chk("mr_new_even", even_valid, 1);
        chk("mr_new_odd", odd_valid, 1);
        chk("mr_new_stall", stall_cycles, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
